// File: rtl/encoder83_irq_if.sv
// ----------------------------------------------------------------------------
// encoder83_irq_if
//   Bundle between a bank of eight request lines plus a code consumer
//   (master side) and the 8-to-3 pending encoder (slave side).
//
//   Signals
//     i_y      8  request lines, synchronous to the encoder clock
//     i_opt    1  line polarity: 0 = active-low, 1 = active-high
//     i_ready  1  consumer accepts o_sel in any cycle where o_valid = 1
//     o_valid  1  o_sel holds an unconsumed code
//     o_sel    3  encoded index of the emitted line
//     o_multi  1  other pending bits were set when o_sel was loaded
//     o_pend   8  current pending register
//
//   Modports
//     master : drives lines/polarity/ready, observes the encoder outputs
//     slave  : the encoder itself
// ----------------------------------------------------------------------------
interface encoder83_irq_if;
    logic [7:0] i_y;
    logic       i_opt;
    logic       i_ready;
    logic       o_valid;
    logic [2:0] o_sel;
    logic       o_multi;
    logic [7:0] o_pend;

    modport master (
        output i_y,
        output i_opt,
        output i_ready,
        input  o_valid,
        input  o_sel,
        input  o_multi,
        input  o_pend
    );

    modport slave (
        input  i_y,
        input  i_opt,
        input  i_ready,
        output o_valid,
        output o_sel,
        output o_multi,
        output o_pend
    );
endinterface

// File: rtl/encoder83_irq.sv
// ----------------------------------------------------------------------------
// encoder83_irq
//   Registered 8-to-3 encoder with sticky pending latches. Events on eight
//   request lines are latched into a pending register and emitted one at a
//   time as a 3-bit index over a valid/ready output stage.
//
//   Parameters
//     EDGE  1 = pend bit set on the assertion edge of its line,
//           0 = pend bit set every cycle the line is asserted
//     RR    0 = fixed priority (lowest index wins),
//           1 = round-robin, search starts after the last emitted index
//
//   Ports
//     i_clk    in   rising-edge clock
//     i_rst_n  in   synchronous active-low reset, clears every register
//     bus      slave modport of encoder83_irq_if (lines, polarity,
//              ready, valid, sel, multi, pend)
//
//   Handshake: o_valid/o_sel/o_multi form a valid/ready source. A code is
//   transferred on a rising edge where o_valid = 1 and i_ready = 1. Once
//   o_valid is high, o_sel and o_multi stay stable until that transfer, and
//   o_valid never drops without a transfer (reset excepted). A new code may
//   be loaded on the same edge as a transfer, giving one code per cycle.
// ----------------------------------------------------------------------------
module encoder83_irq #(
    parameter int EDGE = 1,
    parameter int RR   = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    encoder83_irq_if.slave bus
);

    // Registered state
    logic [7:0] pend_q,  pend_d;
    logic [7:0] a_d_q,   a_d_d;     // line history for edge detection
    logic       valid_q, valid_d;
    logic [2:0] sel_q,   sel_d;
    logic       multi_q, multi_d;
    logic [2:0] ptr_q,   ptr_d;     // last emitted index (round-robin only)

    // Combinational intermediates
    logic [7:0] line_a;
    logic [7:0] set_v;
    logic [7:0] clr_v;
    logic       load;
    logic       found;
    logic [2:0] win;
    logic [2:0] start;
    logic [2:0] idx;

    // Normalise polarity so that 1 always means "asserted".
    assign line_a = bus.i_opt ? bus.i_y : ~bus.i_y;
    assign set_v  = (EDGE != 0) ? (line_a & ~a_d_q) : line_a;

    // Only the registered pend is searched; fresh events wait a cycle.
    assign load = (pend_q != 8'd0) && (!valid_q || bus.i_ready);

    // Winner search. Fixed priority is the round-robin scan with the start
    // pinned at 7, so the scan always begins at index 0.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        start = (RR != 0) ? ptr_q : 3'd7;
        for (int k = 1; k <= 8; k++) begin
            idx = start + 3'(k);
            if (!found && pend_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        clr_v   = 8'd0;
        a_d_d   = line_a;
        valid_d = valid_q;
        sel_d   = sel_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;

        if (load) begin
            clr_v   = 8'd1 << win;
            valid_d = 1'b1;
            sel_d   = win;
            // More than one bit set: clearing the lowest set bit leaves some.
            multi_d = (pend_q & (pend_q - 8'd1)) != 8'd0;
            if (RR != 0) begin
                ptr_d = win;
            end
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        // Set is applied after clear, so a re-arrival on the bit being
        // loaded this cycle keeps it pending.
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q  <= 8'd0;
            a_d_q   <= 8'd0;
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
            multi_q <= 1'b0;
            ptr_q   <= 3'd7;
        end else begin
            pend_q  <= pend_d;
            a_d_q   <= a_d_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_multi = multi_q;
    assign bus.o_pend  = pend_q;

endmodule

// File: tb/tb_encoder83_irq.sv
// ----------------------------------------------------------------------------
// tb_encoder83_irq
//   Two encoder instances: dut_a (edge mode, fixed priority) and dut_b
//   (level mode, round-robin). Directed vectors push hand-computed codes
//   ({multi, sel}) into per-instance expected queues; monitors pop and
//   compare on every accepted handshake. Register-level values are checked
//   directly at the falling edge.
// ----------------------------------------------------------------------------
module tb_encoder83_irq;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    encoder83_irq_if ifa ();
    encoder83_irq_if ifb ();

    encoder83_irq #(.EDGE(1), .RR(0)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa.slave)
    );

    encoder83_irq #(.EDGE(0), .RR(1)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifa.o_valid === 1'b1 && ifa.i_ready === 1'b1) begin
            checks++;
            if (exp_q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: got sel=%0d multi=%0d with no code expected at %0t",
                         ifa.o_sel, ifa.o_multi, $time);
            end else begin
                logic [3:0] e;
                e = exp_q_a.pop_front();
                if ({ifa.o_multi, ifa.o_sel} !== e) begin
                    errors++;
                    $display("FAIL a_code: got multi/sel=%0h expected %0h at %0t",
                             {ifa.o_multi, ifa.o_sel}, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifb.o_valid === 1'b1 && ifb.i_ready === 1'b1) begin
            checks++;
            if (exp_q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got sel=%0d multi=%0d with no code expected at %0t",
                         ifb.o_sel, ifb.o_multi, $time);
            end else begin
                logic [3:0] e;
                e = exp_q_b.pop_front();
                if ({ifb.o_multi, ifb.o_sel} !== e) begin
                    errors++;
                    $display("FAIL b_code: got multi/sel=%0h expected %0h at %0t",
                             {ifb.o_multi, ifb.o_sel}, e, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset with every line asserted (active-low, all zero)
        rst_n       = 1'b0;
        ifa.i_y     = 8'h00;  ifa.i_opt = 1'b0;  ifa.i_ready = 1'b0;
        ifb.i_y     = 8'h00;  ifb.i_opt = 1'b0;  ifb.i_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_a_valid", {7'd0, ifa.o_valid}, 8'h00);
        chk("rst_a_pend",  ifa.o_pend,          8'h00);
        chk("rst_a_sel",   {5'd0, ifa.o_sel},   8'h00);
        chk("rst_b_valid", {7'd0, ifb.o_valid}, 8'h00);
        chk("rst_b_pend",  ifb.o_pend,          8'h00);
        tick();
        @(negedge clk);
        chk("rst_a_valid2", {7'd0, ifa.o_valid}, 8'h00);
        chk("rst_a_pend2",  ifa.o_pend,          8'h00);
        // Move to an idle, deasserted line state before release.
        ifa.i_opt = 1'b1;  ifa.i_y = 8'h00;
        ifb.i_opt = 1'b1;  ifb.i_y = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("idle_a_pend", ifa.o_pend, 8'h00);
        chk("idle_b_pend", ifb.o_pend, 8'h00);

        // 2: loopback, active-low, line 3 pulled low
        ifa.i_opt = 1'b0;  ifa.i_y = 8'hFF;  ifa.i_ready = 1'b1;
        tick();
        tick();
        ifa.i_y = 8'hF7;
        exp_q_a.push_back({1'b0, 3'd3});
        tick();                                  // edge N
        @(negedge clk);
        chk("lb_pend_n",   ifa.o_pend,          8'h08);
        chk("lb_valid_n",  {7'd0, ifa.o_valid}, 8'h00);
        tick();                                  // edge N+1
        @(negedge clk);
        chk("lb_valid_n1", {7'd0, ifa.o_valid}, 8'h01);
        chk("lb_sel_n1",   {5'd0, ifa.o_sel},   8'h03);
        chk("lb_multi_n1", {7'd0, ifa.o_multi}, 8'h00);
        tick();                                  // edge N+2
        @(negedge clk);
        chk("lb_valid_n2", {7'd0, ifa.o_valid}, 8'h00);
        ifa.i_y = 8'hFF;
        tick();

        // 3: priority with backpressure, active-high
        ifa.i_opt = 1'b1;  ifa.i_y = 8'h00;  ifa.i_ready = 1'b0;
        tick();
        ifa.i_y = 8'h24;
        exp_q_a.push_back({1'b1, 3'd2});
        exp_q_a.push_back({1'b0, 3'd5});
        tick();
        ifa.i_y = 8'h00;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pr_valid_hold", {7'd0, ifa.o_valid}, 8'h01);
            chk("pr_sel_hold",   {5'd0, ifa.o_sel},   8'h02);
            chk("pr_multi_hold", {7'd0, ifa.o_multi}, 8'h01);
            chk("pr_pend_hold",  ifa.o_pend,          8'h20);
            tick();
        end
        ifa.i_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("pr_sel5",   {5'd0, ifa.o_sel},   8'h05);
        chk("pr_valid5", {7'd0, ifa.o_valid}, 8'h01);
        chk("pr_multi5", {7'd0, ifa.o_multi}, 8'h00);
        chk("pr_pend0",  ifa.o_pend,          8'h00);
        tick();
        @(negedge clk);
        chk("pr_idle", {7'd0, ifa.o_valid}, 8'h00);

        // 5: set/clear collision on line 4
        tick();
        ifa.i_ready = 1'b0;  ifa.i_y = 8'h11;
        exp_q_a.push_back({1'b1, 3'd0});
        exp_q_a.push_back({1'b0, 3'd4});
        exp_q_a.push_back({1'b0, 3'd4});
        tick();
        ifa.i_y = 8'h00;
        tick();
        @(negedge clk);
        chk("col_sel0",  {5'd0, ifa.o_sel}, 8'h00);
        chk("col_pend",  ifa.o_pend,        8'h10);
        tick();
        ifa.i_ready = 1'b1;  ifa.i_y = 8'h10;    // re-pulse on the loading edge
        tick();
        ifa.i_y = 8'h00;
        @(negedge clk);
        chk("col_sel4a",  {5'd0, ifa.o_sel},   8'h04);
        chk("col_pend4",  ifa.o_pend,          8'h10);
        tick();
        @(negedge clk);
        chk("col_sel4b",  {5'd0, ifa.o_sel},   8'h04);
        chk("col_valid4", {7'd0, ifa.o_valid}, 8'h01);
        chk("col_pend0",  ifa.o_pend,          8'h00);
        tick();
        @(negedge clk);
        chk("col_idle", {7'd0, ifa.o_valid}, 8'h00);

        // 4: round-robin, level mode, lines 0 and 7 held
        ifb.i_ready = 1'b1;  ifb.i_y = 8'h81;
        for (int i = 0; i < 4; i++) begin
            exp_q_b.push_back({1'b1, 3'd0});
            exp_q_b.push_back({1'b1, 3'd7});
        end
        exp_q_b.push_back({1'b1, 3'd0});
        exp_q_b.push_back({1'b0, 3'd7});
        tick();                                  // edge N: pend = 81
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 7) ifb.i_y = 8'h00;
            @(negedge clk);
            chk("rr_no_bubble", {7'd0, ifb.o_valid}, 8'h01);
        end
        tick();
        @(negedge clk);
        chk("rr_idle",  {7'd0, ifb.o_valid}, 8'h00);
        chk("rr_pend0", ifb.o_pend,          8'h00);

        // 6: reset mid-operation
        tick();
        ifa.i_ready = 1'b0;  ifa.i_y = 8'hF8;
        tick();
        ifa.i_y = 8'h00;
        tick();
        @(negedge clk);
        chk("mr_valid_pre", {7'd0, ifa.o_valid}, 8'h01);
        chk("mr_sel_pre",   {5'd0, ifa.o_sel},   8'h03);
        chk("mr_pend_pre",  ifa.o_pend,          8'hF0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.i_ready = 1'b1;
        @(negedge clk);
        chk("mr_valid", {7'd0, ifa.o_valid}, 8'h00);
        chk("mr_sel",   {5'd0, ifa.o_sel},   8'h00);
        chk("mr_multi", {7'd0, ifa.o_multi}, 8'h00);
        chk("mr_pend",  ifa.o_pend,          8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("mr_quiet", {7'd0, ifa.o_valid}, 8'h00);
        end

        // Every expected code must have been consumed.
        chk("a_queue_empty", 8'(exp_q_a.size()), 8'h00);
        chk("b_queue_empty", 8'(exp_q_b.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
